addr_update_sequencer: RTL
==========================

Name: addr_update_sequencer

Overview:
- Sequences target and virtual-target dynamic-address updates into the StdbyCtrlMode CSR hwif write strobes.
- Update sources: RSTDAA, SETDASA, SETNEWDA and SETAASA events from the CCC handler.
- Latches each event as pending, grants one per transaction by fixed priority, drives a one-cycle CSR write, then confirms the CSR readback.
- Reports completion, loss and timeout pulses towards the interrupt logic.
- Sits between the target CCC decoder and the CSR hwif input of the register block.

Parameters:
- ConfirmTimeout, 4: maximum cycles in CONFIRM waiting for a readback match; legal range 1..255.
- AddrWidth, 7: width of I3C dynamic and static addresses.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- rstdaa_i  in  1  RSTDAA event pulse; clears both the main and the virtual address.
- setdasa_valid_i  in  1  SETDASA event pulse.
- setdasa_addr_i  in  AddrWidth  SETDASA address.
- setdasa_virt_i  in  1  SETDASA targets the virtual device.
- setnewda_valid_i  in  1  SETNEWDA event pulse.
- setnewda_addr_i  in  AddrWidth  new address.
- setnewda_virt_i  in  1  SETNEWDA targets the virtual device.
- setaasa_i  in  1  SETAASA event for the main device.
- setaasa_virt_i  in  1  SETAASA event for the virtual device.
- static_addr_i  in  AddrWidth  STATIC_ADDR CSR value.
- virt_static_addr_i  in  AddrWidth  VIRT_STATIC_ADDR CSR value.
- dyn_addr_rb_i  in  AddrWidth  DYNAMIC_ADDR readback.
- dyn_addr_valid_rb_i  in  1  DYNAMIC_ADDR_VALID readback.
- virt_dyn_addr_rb_i  in  AddrWidth  VIRT_DYNAMIC_ADDR readback.
- virt_dyn_addr_valid_rb_i  in  1  VIRT_DYNAMIC_ADDR_VALID readback.
- dyn_addr_we_o  out  1  write strobe for DYNAMIC_ADDR and DYNAMIC_ADDR_VALID.
- dyn_addr_next_o  out  AddrWidth  next DYNAMIC_ADDR.
- dyn_addr_valid_next_o  out  1  next DYNAMIC_ADDR_VALID.
- virt_dyn_addr_we_o  out  1  virtual-device write strobe.
- virt_dyn_addr_next_o  out  AddrWidth  next VIRT_DYNAMIC_ADDR.
- virt_dyn_addr_valid_next_o  out  1  next VIRT_DYNAMIC_ADDR_VALID.
- busy_o  out  1  state is not IDLE, or any event is pending.
- dyn_addr_stat_o  out  1  one-cycle pulse: update confirmed (drives STBY_CR_DYN_ADDR_STAT.next).
- drop_o  out  1  one-cycle pulse: a pending event was overwritten.
- timeout_o  out  1  one-cycle pulse: readback mismatch at timeout.

Behaviour:
- Reset: all outputs 0, all pending flags clear, state IDLE, timeout counter 0. Reset asserted mid-operation aborts the transaction with no write strobe in the following cycle.
- Pending slots: RSTDAA (flag only), DASA, NEWDA, AASA. Each slot holds address and virt flag; AASA holds separate main and virt bits.
- Each slot is set on its input pulse, with payload latched.
- An event arriving while its slot is already set overwrites the payload and pulses drop_o for one cycle. AASA main/virt bits OR together and never drop.
- An event arriving in the same cycle its slot is granted re-sets the slot with the new payload; this is not a drop.
- RSTDAA arrival also clears pending NEWDA. A NEWDA arriving in the same cycle as RSTDAA is discarded without drop_o.
- Grant priority: RSTDAA > DASA > NEWDA > AASA. Arbitration occurs only in IDLE. The winning slot is cleared and its payload moved to a target register.
- FSM: IDLE -> APPLY when any slot is pending; APPLY -> CONFIRM; CONFIRM -> DONE on readback match; CONFIRM -> IDLE at timeout; DONE -> IDLE.
- APPLY (exactly one cycle) outputs per grant:
  - RSTDAA: both we=1, next addr=0, next valid=0.
  - DASA/NEWDA with virt=0: dyn we=1, next=addr, valid=1. With virt=1: virt we=1 instead.
  - AASA: dyn we if the main bit is set, with next=static_addr_i. Virt we if the virt bit is set, with next=virt_static_addr_i. Static values are sampled at grant. Valid=1.
  - All _next outputs are 0 outside APPLY.
- CONFIRM starts the cycle after APPLY.
  - Each cycle, compare readback address and valid of every written register with the values written.
  - All match -> DONE. DONE pulses dyn_addr_stat_o for one cycle.
  - Counter starts at 0, increments per CONFIRM cycle, and saturates at ConfirmTimeout.
  - Mismatch with counter == ConfirmTimeout-1 -> timeout_o pulse, go to IDLE, no dyn_addr_stat_o.
- Minimum back-to-back throughput: one update per 4 cycles (IDLE, APPLY, CONFIRM, DONE).
- Address paths are width-exact: no truncation or extension.

Decomposition:
- i3c_pkg holds:
  - the addr_upd_state_e enum (IDLE, APPLY, CONFIRM, DONE);
  - the addr_upd_kind_e enum (RSTDAA, DASA, NEWDA, AASA);
  - the addr_upd_req_t struct {kind, addr, virt, aasa_main, aasa_virt}.
- One sub-module, addr_update_pending: slot registers, drop detection and the fixed-priority grant encoder. The FSM and confirm counter stay in the top module.

Test Plan:
- Reset, then setdasa_valid_i=1, addr=0x2A, virt=0 for one cycle; CSR model echoes writes with 1-cycle latency -> dyn_addr_we_o high exactly 1 cycle with next=0x2A, valid=1; dyn_addr_stat_o pulses 3 cycles after the grant.
- rstdaa_i and setnewda_valid_i (0x10) in the same cycle -> only the RSTDAA write occurs (both we, next=0), no drop_o, no NEWDA write afterwards.
- setaasa_i=1, setaasa_virt_i=1, static_addr_i=0x31, virt_static_addr_i=0x32 -> both we high in the same APPLY cycle, next values 0x31 and 0x32.
- Two SETDASA pulses (0x11, then 0x12) while a NEWDA transaction is in CONFIRM -> drop_o pulses once; the following DASA transaction writes 0x12.
- CSR model ignores writes, ConfirmTimeout=4 -> timeout_o pulses 4 cycles after APPLY, no stat pulse, busy_o low the next cycle.
- rst_ni low during APPLY -> the next cycle shows all outputs 0 and no pending slots; no stat pulse after release.

Source files
------------

// File: rtl/i3c_pkg.sv
// Shared types for the target dynamic-address update path: FSM states,
// update kinds and the request record handed from the pending slots to the sequencer.
package i3c_pkg;

    localparam int unsigned AddrW = 7;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CONFIRM,
        DONE
    } addr_upd_state_e;

    typedef enum logic [1:0] {
        RSTDAA,
        DASA,
        NEWDA,
        AASA
    } addr_upd_kind_e;

    typedef struct packed {
        addr_upd_kind_e   kind;
        logic [AddrW-1:0] addr;
        logic             virt;
        logic             aasa_main;
        logic             aasa_virt;
    } addr_upd_req_t;

endpackage

// File: rtl/addr_update_pending.sv
// Pending-event slots for dynamic-address updates: latches CCC events, flags
// overwritten events and presents the highest-priority request to the sequencer.
module addr_update_pending
    import i3c_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             grant_en_i,
    input  logic             rstdaa_i,
    input  logic             setdasa_valid_i,
    input  logic [AddrW-1:0] setdasa_addr_i,
    input  logic             setdasa_virt_i,
    input  logic             setnewda_valid_i,
    input  logic [AddrW-1:0] setnewda_addr_i,
    input  logic             setnewda_virt_i,
    input  logic             setaasa_i,
    input  logic             setaasa_virt_i,
    output logic             pending_o,
    output addr_upd_req_t    req_o,
    output logic             drop_o
);

    logic             rst_q;
    logic             dasa_q;
    logic [AddrW-1:0] dasa_addr_q;
    logic             dasa_virt_q;
    logic             newda_q;
    logic [AddrW-1:0] newda_addr_q;
    logic             newda_virt_q;
    logic             aasa_main_q;
    logic             aasa_virt_q;
    logic             drop_q;

    logic gnt_rst;
    logic gnt_dasa;
    logic gnt_newda;
    logic gnt_aasa;

    // Fixed priority RSTDAA > DASA > NEWDA > AASA; a grant clears its slot on the same edge.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        gnt_rst   = 1'b0;
        gnt_dasa  = 1'b0;
        gnt_newda = 1'b0;
        gnt_aasa  = 1'b0;
        req_o     = '{kind: RSTDAA, addr: '0, virt: 1'b0, aasa_main: 1'b0, aasa_virt: 1'b0};
        pending_o = rst_q | dasa_q | newda_q | aasa_main_q | aasa_virt_q;
        if (rst_q) begin
            gnt_rst = grant_en_i;
        end else if (dasa_q) begin
            gnt_dasa   = grant_en_i;
            req_o.kind = DASA;
            req_o.addr = dasa_addr_q;
            req_o.virt = dasa_virt_q;
        end else if (newda_q) begin
            gnt_newda  = grant_en_i;
            req_o.kind = NEWDA;
            req_o.addr = newda_addr_q;
            req_o.virt = newda_virt_q;
        end else if (aasa_main_q || aasa_virt_q) begin
            gnt_aasa        = grant_en_i;
            req_o.kind      = AASA;
            req_o.aasa_main = aasa_main_q;
            req_o.aasa_virt = aasa_virt_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rst_q        <= 1'b0;
            dasa_q       <= 1'b0;
            dasa_addr_q  <= '0;
            dasa_virt_q  <= 1'b0;
            newda_q      <= 1'b0;
            newda_addr_q <= '0;
            newda_virt_q <= 1'b0;
            aasa_main_q  <= 1'b0;
            aasa_virt_q  <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            rst_q <= rstdaa_i | (rst_q & ~gnt_rst);

            if (setdasa_valid_i) begin
                dasa_q      <= 1'b1;
                dasa_addr_q <= setdasa_addr_i;
                dasa_virt_q <= setdasa_virt_i;
            end else if (gnt_dasa) begin
                dasa_q <= 1'b0;
            end

            // RSTDAA invalidates any address change queued before or alongside it.
            if (rstdaa_i) begin
                newda_q <= 1'b0;
            end else if (setnewda_valid_i) begin
                newda_q      <= 1'b1;
                newda_addr_q <= setnewda_addr_i;
                newda_virt_q <= setnewda_virt_i;
            end else if (gnt_newda) begin
                newda_q <= 1'b0;
            end

            aasa_main_q <= setaasa_i | (aasa_main_q & ~gnt_aasa);
            aasa_virt_q <= setaasa_virt_i | (aasa_virt_q & ~gnt_aasa);

            drop_q <= (rstdaa_i & rst_q & ~gnt_rst)
                    | (setdasa_valid_i & dasa_q & ~gnt_dasa)
                    | (setnewda_valid_i & ~rstdaa_i & newda_q & ~gnt_newda);
        end
    end

    assign drop_o = drop_q;

endmodule

// File: rtl/addr_update_sequencer.sv
// Turns granted address-update requests into one-cycle CSR hwif writes and
// confirms them against the CSR readback, reporting completion or timeout.
module addr_update_sequencer
    import i3c_pkg::*;
#(
    parameter int unsigned ConfirmTimeout = 4,
    parameter int unsigned AddrWidth      = AddrW
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rstdaa_i,
    input  logic                 setdasa_valid_i,
    input  logic [AddrWidth-1:0] setdasa_addr_i,
    input  logic                 setdasa_virt_i,
    input  logic                 setnewda_valid_i,
    input  logic [AddrWidth-1:0] setnewda_addr_i,
    input  logic                 setnewda_virt_i,
    input  logic                 setaasa_i,
    input  logic                 setaasa_virt_i,
    input  logic [AddrWidth-1:0] static_addr_i,
    input  logic [AddrWidth-1:0] virt_static_addr_i,
    input  logic [AddrWidth-1:0] dyn_addr_rb_i,
    input  logic                 dyn_addr_valid_rb_i,
    input  logic [AddrWidth-1:0] virt_dyn_addr_rb_i,
    input  logic                 virt_dyn_addr_valid_rb_i,
    output logic                 dyn_addr_we_o,
    output logic [AddrWidth-1:0] dyn_addr_next_o,
    output logic                 dyn_addr_valid_next_o,
    output logic                 virt_dyn_addr_we_o,
    output logic [AddrWidth-1:0] virt_dyn_addr_next_o,
    output logic                 virt_dyn_addr_valid_next_o,
    output logic                 busy_o,
    output logic                 dyn_addr_stat_o,
    output logic                 drop_o,
    output logic                 timeout_o
);

    localparam logic [7:0] TimeoutCnt = 8'(ConfirmTimeout);
    localparam logic [7:0] LastCnt    = 8'(ConfirmTimeout - 1);

    addr_upd_state_e state_q, state_d;
    logic [7:0]      cnt_q;
    logic            pending;
    addr_upd_req_t   req;
    logic            grant;
    logic            match;

    logic                 wr_dyn_en_q;
    logic [AddrWidth-1:0] wr_dyn_addr_q;
    logic                 wr_dyn_valid_q;
    logic                 wr_virt_en_q;
    logic [AddrWidth-1:0] wr_virt_addr_q;
    logic                 wr_virt_valid_q;

    addr_update_pending u_pending (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .grant_en_i       (state_q == IDLE),
        .rstdaa_i         (rstdaa_i),
        .setdasa_valid_i  (setdasa_valid_i),
        .setdasa_addr_i   (setdasa_addr_i),
        .setdasa_virt_i   (setdasa_virt_i),
        .setnewda_valid_i (setnewda_valid_i),
        .setnewda_addr_i  (setnewda_addr_i),
        .setnewda_virt_i  (setnewda_virt_i),
        .setaasa_i        (setaasa_i),
        .setaasa_virt_i   (setaasa_virt_i),
        .pending_o        (pending),
        .req_o            (req),
        .drop_o           (drop_o)
    );

    assign grant = (state_q == IDLE) && pending;

    // Only registers actually written in APPLY take part in the readback comparison.
    assign match = (!wr_dyn_en_q
                    || (dyn_addr_rb_i == wr_dyn_addr_q && dyn_addr_valid_rb_i == wr_dyn_valid_q))
                && (!wr_virt_en_q
                    || (virt_dyn_addr_rb_i == wr_virt_addr_q
                        && virt_dyn_addr_valid_rb_i == wr_virt_valid_q));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pending) state_d = APPLY;
            APPLY:   state_d = CONFIRM;
            CONFIRM: begin
                if (match)                 state_d = DONE;
                else if (cnt_q == LastCnt) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            wr_dyn_en_q     <= 1'b0;
            wr_dyn_addr_q   <= '0;
            wr_dyn_valid_q  <= 1'b0;
            wr_virt_en_q    <= 1'b0;
            wr_virt_addr_q  <= '0;
            wr_virt_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == CONFIRM) begin
                cnt_q <= (cnt_q == TimeoutCnt) ? cnt_q : cnt_q + 8'd1;
            end else begin
                cnt_q <= '0;
            end

            // Write values are frozen at grant so the static CSRs are sampled exactly once.
            if (grant) begin
                wr_dyn_en_q     <= 1'b0;
                wr_dyn_addr_q   <= '0;
                wr_dyn_valid_q  <= 1'b1;
                wr_virt_en_q    <= 1'b0;
                wr_virt_addr_q  <= '0;
                wr_virt_valid_q <= 1'b1;
                unique case (req.kind)
                    RSTDAA: begin
                        wr_dyn_en_q     <= 1'b1;
                        wr_dyn_valid_q  <= 1'b0;
                        wr_virt_en_q    <= 1'b1;
                        wr_virt_valid_q <= 1'b0;
                    end
                    DASA, NEWDA: begin
                        if (req.virt) begin
                            wr_virt_en_q   <= 1'b1;
                            wr_virt_addr_q <= req.addr;
                        end else begin
                            wr_dyn_en_q   <= 1'b1;
                            wr_dyn_addr_q <= req.addr;
                        end
                    end
                    AASA: begin
                        wr_dyn_en_q    <= req.aasa_main;
                        wr_dyn_addr_q  <= static_addr_i;
                        wr_virt_en_q   <= req.aasa_virt;
                        wr_virt_addr_q <= virt_static_addr_i;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dyn_addr_we_o              = (state_q == APPLY) && wr_dyn_en_q;
    assign dyn_addr_next_o            = (state_q == APPLY) ? wr_dyn_addr_q : '0;
    assign dyn_addr_valid_next_o      = (state_q == APPLY) && wr_dyn_valid_q;
    assign virt_dyn_addr_we_o         = (state_q == APPLY) && wr_virt_en_q;
    assign virt_dyn_addr_next_o       = (state_q == APPLY) ? wr_virt_addr_q : '0;
    assign virt_dyn_addr_valid_next_o = (state_q == APPLY) && wr_virt_valid_q;

    assign busy_o          = (state_q != IDLE) || pending;
    assign dyn_addr_stat_o = (state_q == DONE);
    assign timeout_o       = (state_q == CONFIRM) && !match && (cnt_q == LastCnt);

endmodule
